axil_reg_arbiter: RTL and testbench
===================================

Name: axil_reg_arbiter

Overview:
- Shares one AXI4-Lite master port, driving the panda_pcap register slave, between two simple register-access requesters (e.g. a host bridge and an on-chip sequencer).
- Each requester issues single 32-bit read/write transactions through a valid/done interface.
- Arbitration is round-robin. One transaction is in flight at a time, and the block sequences the AXI channel handshakes.

Parameters:
- ADDR_W, 32, address width of requester and AXI address buses
- DATA_W, 32, data width (fixed 32; WSTRB = DATA_W/8)
- TIMEOUT_CYCLES, 1024, watchdog limit; only used when AXIL_ARB_TIMEOUT_EN is defined

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- req_valid  in  2  per-requester request; held high until matching req_done
- req_wr  in  2  1=write, 0=read
- req_addr  in  2*ADDR_W  packed addresses, requester 0 in LSBs
- req_wdata  in  2*DATA_W  packed write data
- req_done  out  2  one-cycle completion pulse
- req_rdata  out  DATA_W  read data, valid with req_done
- req_resp  out  2  AXI response code, valid with req_done
- m_axi_awaddr/awprot/awvalid  out  ADDR_W/3/1  write address channel; awprot is always 0
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_W/4/1  write data channel; wstrb is always 4'hF
- m_axi_wready  in  1
- m_axi_bresp/bvalid  in  2/1
- m_axi_bready  out  1
- m_axi_araddr/arprot/arvalid  out  ADDR_W/3/1
- m_axi_arready  in  1
- m_axi_rdata/rresp/rvalid  in  DATA_W/2/1
- m_axi_rready  out  1

Behaviour:
- Interface: one clock, ACLK. ARESETN is asynchronous and active-low.
- Reset values: all valid/ready outputs 0; req_done 0; req_rdata 0; req_resp 0; state IDLE; round-robin pointer last_grant=1, so requester 0 wins the first tie.
- All outputs are registered.

State machine:
- IDLE
  - If any req_valid is set, grant and go to WR or RD.
  - If both are set, grant ~last_grant.
  - Latch addr, wdata and the wr bit of the granted requester; update last_grant.
- WR
  - Assert awvalid and wvalid together.
  - Drop each one independently on its own handshake (valid&ready).
  - When both are done (same cycle or different cycles), go to WB.
- WB
  - bready=1.
  - On bvalid: latch bresp and go to DONE.
- RD
  - arvalid=1.
  - On arready go to RR.
- RR
  - rready=1.
  - On rvalid: latch rdata and rresp and go to DONE.
- DONE
  - Pulse req_done[grant] for one cycle; return to IDLE.
  - req_valid is not re-sampled in this cycle, so the requester has one cycle to drop valid after done.
  - A valid still high in IDLE is treated as a new request.

Timing and protocol rules:
- Latency with an always-ready slave and bvalid/rvalid one cycle after the address handshake: req_valid rise to req_done = 5 cycles.
- Address, data and wr are captured only at grant. Changes to req_* while granted are ignored.
- AXI valid signals never drop before their ready, per AXI4-Lite rules.
- SLVERR or DECERR responses are passed through unmodified in req_resp; the state machine continues normally.
- ARESETN asserted mid-transaction: immediate return to reset values. No done pulse is issued for the aborted request.
- The non-granted requester waits, with no done, until the current transaction reaches DONE.

Optional Feature:
- Macro: AXIL_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter resets on entry to WR or RD and counts every cycle in WR, WB, RD and RR.
  - At TIMEOUT_CYCLES the block drops all AXI valid/ready outputs and goes to DONE with req_resp=2'b10 (SLVERR) and req_rdata=32'hDEAD_DEAD.
- When undefined: no counter; the block waits indefinitely.

Decomposition:
- Package axil_arb_pkg holds:
  - state enum (IDLE, WR, WB, RD, RR, DONE)
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - TIMEOUT_RDATA constant
- Natural sub-module: axil_rr_arbiter, a two-way round-robin grant with pointer, used in IDLE only.
- The AXI sequencer stays in the top module.

Test Plan:
- Single write from req 0, addr 0x0000_0004, data 0xABCD0001, always-ready slave -> awaddr/wdata match, wstrb=F; req_done[0] 5 cycles after valid; resp 0.
- Read back the same address from req 1 -> req_rdata=0xABCD0001, resp 0, only req_done[1] pulses.
- Both requesters valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; never two in flight.
- Slave delays awready 3 cycles and wready 1 cycle, then returns bresp=2'b10 -> valids are held until their own handshakes; req_resp=2'b10.
- ARESETN pulsed low during RR -> all outputs 0 asynchronously, no done; the next request completes normally.
- With AXIL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready -> done 16 cycles after RD entry, resp 2'b10, rdata 0xDEADDEAD.

Source files
------------

// File: rtl/axil_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : axil_arb_pkg
// Brief  : Shared types and constants for the AXI4-Lite register arbiter.
//          These include the sequencer state encoding, the AXI response codes
//          and the read data returned when the watchdog aborts a read.
// Rev    : 1.0 - initial release
// ============================================================================
package axil_arb_pkg;

  // Sequencer states. One transaction is in flight from WR/RD until DONE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WB   = 3'd2,
    ST_RD   = 3'd3,
    ST_RR   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;

  // Marker returned on a watchdog abort so that software can spot it.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

endpackage : axil_arb_pkg
`default_nettype wire

// File: rtl/axil_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axil_rr_arbiter
// Brief  : Two-way round-robin grant. The grant is combinational from the
//          requests. The pointer remembers the last winner and only advances
//          when the caller accepts a grant (en_i). It resets to 1, so
//          requester 0 wins the first tie.
// Rev    : 1.0 - initial release
// ============================================================================
module axil_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       gnt_valid_o
);

  logic last_grant_q;

  // Pick the requester: on a tie, the one that did not win last time.
  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_o = ~last_grant_q;
    end else begin
      gnt_o = req_i[1];
    end
  end

  // Record the winner whenever a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (en_i && gnt_valid_o) begin
      last_grant_q <= gnt_o;
    end
  end

endmodule : axil_rr_arbiter
`default_nettype wire

// File: rtl/axil_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axil_reg_arbiter
// Brief  : Shares one AXI4-Lite master port between two single-beat register
//          requesters. Arbitration is round-robin, and only one transaction
//          is in flight at a time. Every output is driven from a register.
//          Optional build macro AXIL_ARB_TIMEOUT_EN adds a 16-bit watchdog.
//          After TIMEOUT_CYCLES busy cycles it aborts the transaction with
//          SLVERR and read data 32'hDEAD_DEAD.
// Rev    : 1.0 - initial release
// ============================================================================
module axil_reg_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // requester side
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_wr,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     req_rdata,
  output logic [1:0]            req_resp,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cfg
    $error("axil_reg_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e              state_q;
  logic                gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [1:0]          done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;

  logic                w_idle;
  logic                w_gnt;
  logic                w_gnt_valid;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_ok;
  logic                w_w_ok;

`ifdef AXIL_ARB_TIMEOUT_EN
  logic [15:0]         cnt_q;
  logic                w_busy;
  logic                w_tmo;
`endif

  assign w_idle = (state_q == ST_IDLE);

  axil_rr_arbiter u_rr (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .req_i       (req_valid),
    .en_i        (w_idle),
    .gnt_o       (w_gnt),
    .gnt_valid_o (w_gnt_valid)
  );

  // Operands of the requester that is about to be granted.
  assign w_sel_addr  = w_gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Each write channel finishes on its own handshake. A channel that already
  // handshook in an earlier cycle counts as finished.
  assign w_aw_hs = awvalid_q && m_axi_awready;
  assign w_w_hs  = wvalid_q  && m_axi_wready;
  assign w_aw_ok = w_aw_hs || !awvalid_q;
  assign w_w_ok  = w_w_hs  || !wvalid_q;

`ifdef AXIL_ARB_TIMEOUT_EN
  assign w_busy = (state_q == ST_WR) || (state_q == ST_WB) ||
                  (state_q == ST_RD) || (state_q == ST_RR);
  assign w_tmo  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  // Transaction sequencer: grant, drive the AXI handshakes, then pulse done.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      done_q <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
      if (w_busy) begin
        cnt_q <= cnt_q + 16'd1;
      end
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            gnt_q   <= w_gnt;
            addr_q  <= w_sel_addr;
            wdata_q <= w_sel_wdata;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (req_wr[w_gnt]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD;
            end
          end
        end
        ST_WR: begin
          if (w_aw_hs) begin
            awvalid_q <= 1'b0;
          end
          if (w_w_hs) begin
            wvalid_q <= 1'b0;
          end
          if (w_aw_ok && w_w_ok) begin
            bready_q <= 1'b1;
            state_q  <= ST_WB;
          end
        end
        ST_WB: begin
          if (m_axi_bvalid) begin
            bready_q      <= 1'b0;
            resp_q        <= m_axi_bresp;
            done_q[gnt_q] <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_RD: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RR;
          end
        end
        ST_RR: begin
          if (m_axi_rvalid) begin
            rready_q      <= 1'b0;
            rdata_q       <= m_axi_rdata;
            resp_q        <= m_axi_rresp;
            done_q[gnt_q] <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Requests are not sampled here, so the requester has one cycle
          // to drop its valid after seeing done.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
`ifdef AXIL_ARB_TIMEOUT_EN
      // The watchdog abort overrides any completion in the same cycle.
      if (w_busy && w_tmo) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        resp_q        <= RESP_SLVERR;
        rdata_q       <= DATA_W'(TIMEOUT_RDATA);
        done_q[gnt_q] <= 1'b1;
        state_q       <= ST_DONE;
      end
`endif
    end
  end

  assign req_done      = done_q;
  assign req_rdata     = rdata_q;
  assign req_resp      = resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule : axil_reg_arbiter
`default_nettype wire

// File: tb/tb_axil_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axil_reg_arbiter
// Brief  : Self-checking bench for axil_reg_arbiter. It contains a
//          behavioural AXI4-Lite slave, a reference register map and a
//          round-robin expectation model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_axil_reg_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic [1:0]          req_valid;
  logic [1:0]          req_wr;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_done;
  logic [DATA_W-1:0]   req_rdata;
  logic [1:0]          req_resp;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [3:0]          m_axi_wstrb;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [2:0]          m_axi_arprot;
  logic                m_axi_arvalid;
  logic                m_axi_arready;
  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;
  logic                m_axi_rvalid;
  logic                m_axi_rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axil_reg_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_done(req_done), .req_rdata(req_rdata),
    .req_resp(req_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- behavioural AXI4-Lite slave ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_lat = 0;
  bit          ar_never = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] slv_mem [16] = '{default: 32'h0};
  int          aw_cnt, w_cnt, ar_cnt, r_wait;
  logic        got_aw, got_w, b_pend, r_pend;
  logic [31:0] cap_addr, cap_data, r_addr;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic [2:0]  last_awprot;
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] addr_now, data_now;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_dly);
  assign m_axi_arready = m_axi_arvalid && !ar_never && (ar_cnt >= ar_dly);
  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid  && m_axi_wready;
  assign ar_hs    = m_axi_arvalid && m_axi_arready;
  assign addr_now = aw_hs ? m_axi_awaddr : cap_addr;
  assign data_now = w_hs  ? m_axi_wdata  : cap_data;

  // Responses come back one idle cycle after the handshake is registered.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      cap_addr <= '0; cap_data <= '0; r_addr <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin
        got_aw <= 1'b1; cap_addr <= m_axi_awaddr;
        last_awaddr <= m_axi_awaddr; last_awprot <= m_axi_awprot;
      end
      if (w_hs) begin
        got_w <= 1'b1; cap_data <= m_axi_wdata;
        last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb;
      end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        slv_mem[addr_now[5:2]] <= data_now;
        b_pend <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (b_pend) begin
        m_axi_bvalid <= 1'b1; m_axi_bresp <= b_resp_cfg; b_pend <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (ar_hs) begin
        r_pend <= 1'b1; r_wait <= r_lat; r_addr <= m_axi_araddr;
      end else if (r_pend) begin
        if (r_wait == 0) begin
          m_axi_rvalid <= 1'b1; m_axi_rdata <= slv_mem[r_addr[5:2]];
          m_axi_rresp <= r_resp_cfg; r_pend <= 1'b0;
        end else begin
          r_wait <= r_wait - 1;
        end
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitors ----------------
  int   hold_viol = 0, excl_viol = 0, aw_hi = 0, w_hi = 0;
  logic p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic inflight;

  // A valid that was high without ready must still be high a cycle later.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if ((p_awv && !p_awr && !m_axi_awvalid) || (p_wv && !p_wr && !m_axi_wvalid) ||
          (p_arv && !p_arr && !m_axi_arvalid))
        hold_viol <= hold_viol + 1;
    end
    p_awv <= m_axi_awvalid; p_awr <= m_axi_awready;
    p_wv  <= m_axi_wvalid;  p_wr  <= m_axi_wready;
    p_arv <= m_axi_arvalid; p_arr <= m_axi_arready;
    if (m_axi_awvalid) aw_hi <= aw_hi + 1;
    if (m_axi_wvalid)  w_hi  <= w_hi + 1;
  end

  // Only one transaction may be between its address handshake and its done.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      inflight <= 1'b0;
    end else begin
      if ((aw_hs || ar_hs) && inflight) excl_viol <= excl_viol + 1;
      if ($countones(req_done) > 1) excl_viol <= excl_viol + 1;
      if (aw_hs || ar_hs) inflight <= 1'b1;
      else if (req_done != 2'b00) inflight <= 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, observed hang expected finish");
    $fatal(1, "tb watchdog");
  end

  // ---------------- reference model & helpers ----------------
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  bit          ref_last = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_wr[k] = wr;
    req_addr[k*ADDR_W +: ADDR_W]  = a;
    req_wdata[k*DATA_W +: DATA_W] = d;
  endtask

  // One transaction from requester k. Latency counts the cycle in which
  // valid rises as cycle 1.
  task automatic run_txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int bound, output logic [1:0] dn, output logic [31:0] rd,
                         output logic [1:0] rs, output int lat, output int ar_cyc);
    @(posedge ACLK); #1;
    drive_req(k, wr, a, d);
    req_valid[k] = 1'b1;
    lat = 0; ar_cyc = 0; dn = 2'b00; rd = '0; rs = '0;
    while (lat < bound && dn == 2'b00) begin
      @(negedge ACLK); lat++;
      if (ar_cyc == 0 && m_axi_arvalid) ar_cyc = lat;
      dn = req_done; rd = req_rdata; rs = req_resp;
    end
    @(posedge ACLK); #1;
    req_valid[k] = 1'b0;
  endtask

  // ---------------- directed + randomized sequence ----------------
  logic [1:0]  dn, rs;
  logic [31:0] rd, dval;
  int          lat, arc, got, guard, ek, aw0, w0, done_seen;
  bit          cur_wr [2];
  int          cur_idx [2];
  logic [31:0] cur_data [2];

  initial begin
    ARESETN = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge ACLK);
    check("reset_axi_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
    check("reset_done", req_done, 2'b00);
    check("reset_rdata_resp", {req_rdata, req_resp}, 34'h0);
    ARESETN = 1'b1;

    // Single write from requester 0.
    run_txn(0, 1'b1, 32'h0000_0004, 32'hABCD_0001, 50, dn, rd, rs, lat, arc);
    ref_mem[1] = 32'hABCD_0001; ref_last = 1'b0;
    check("wr0_done", dn, 2'b01);
    check("wr0_latency", lat, 5);
    check("wr0_resp", rs, 2'b00);
    check("wr0_awaddr_wdata", {last_awaddr, last_wdata}, {32'h0000_0004, 32'hABCD_0001});
    check("wr0_wstrb_awprot", {last_wstrb, last_awprot}, {4'hF, 3'b000});

    // Read back from requester 1.
    run_txn(1, 1'b0, 32'h0000_0004, 32'h0, 50, dn, rd, rs, lat, arc);
    ref_last = 1'b1;
    check("rd1_done", dn, 2'b10);
    check("rd1_rdata", rd, ref_mem[1]);
    check("rd1_resp", rs, 2'b00);
    check("rd1_latency", lat, 5);

    // Both requesters continuously valid with random operations.
    @(posedge ACLK); #1;
    for (int k = 0; k < 2; k++) begin
      cur_wr[k] = 1'($urandom_range(0, 1)); cur_idx[k] = $urandom_range(0, 3);
      cur_data[k] = $urandom;
      drive_req(k, cur_wr[k], 32'(cur_idx[k] * 4), cur_data[k]);
    end
    req_valid = 2'b11;
    got = 0; guard = 0;
    while (got < 6 && guard < 400) begin
      @(negedge ACLK); guard++;
      if (req_done != 2'b00) begin
        ek = ref_last ? 0 : 1;
        ref_last = (ek == 1);
        check("rr_grant", req_done, 64'(2'b01 << ek));
        if (!cur_wr[ek]) check("rr_rdata", req_rdata, ref_mem[cur_idx[ek]]);
        else ref_mem[cur_idx[ek]] = cur_data[ek];
        check("rr_resp", req_resp, 2'b00);
        got++;
        @(posedge ACLK); #1;
        if (got == 6) begin
          req_valid = 2'b00;
        end else begin
          cur_wr[ek] = 1'($urandom_range(0, 1)); cur_idx[ek] = $urandom_range(0, 3);
          cur_data[ek] = $urandom;
          drive_req(ek, cur_wr[ek], 32'(cur_idx[ek] * 4), cur_data[ek]);
        end
      end
    end
    check("rr_txn_count", got, 6);

    // Slow slave: awready after 3 cycles, wready after 1, SLVERR response.
    aw_dly = 3; w_dly = 1; b_resp_cfg = 2'b10;
    aw0 = aw_hi; w0 = w_hi; dval = $urandom;
    run_txn(1, 1'b1, 32'h0000_0010, dval, 80, dn, rd, rs, lat, arc);
    ref_mem[4] = dval; ref_last = 1'b1;
    check("slow_done", dn, 2'b10);
    check("slow_resp_slverr", rs, 2'b10);
    check("slow_awvalid_cycles", aw_hi - aw0, 4);
    check("slow_wvalid_cycles", w_hi - w0, 2);
    aw_dly = 0; w_dly = 0; b_resp_cfg = 2'b00;

    // Reset asserted while waiting for read data.
    r_lat = 20;
    @(posedge ACLK); #1;
    drive_req(0, 1'b0, 32'h0000_0004, 32'h0);
    req_valid[0] = 1'b1;
    guard = 0;
    while (!m_axi_rready && guard < 50) begin @(negedge ACLK); guard++; end
    check("rst_reached_rr", m_axi_rready, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_async_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
    check("rst_async_req", {req_done, req_rdata, req_resp}, 36'h0);
    req_valid = 2'b00;
    done_seen = 0;
    repeat (3) begin @(negedge ACLK); if (req_done != 2'b00) done_seen++; end
    ARESETN = 1'b1; ref_last = 1'b1; r_lat = 0;
    repeat (25) begin @(negedge ACLK); if (req_done != 2'b00) done_seen++; end
    check("rst_no_done", done_seen, 0);
    run_txn(1, 1'b0, 32'h0000_0004, 32'h0, 50, dn, rd, rs, lat, arc);
    ref_last = 1'b1;
    check("post_rst_done", dn, 2'b10);
    check("post_rst_rdata", rd, ref_mem[1]);

    check("axi_valid_hold", hold_viol, 0);
    check("single_in_flight", excl_viol, 0);

`ifdef AXIL_ARB_TIMEOUT_EN
    // Slave never accepts the read address: the watchdog must abort.
    ar_never = 1'b1;
    run_txn(0, 1'b0, 32'h0000_0008, 32'h0, 100, dn, rd, rs, lat, arc);
    check("tmo_done", dn, 2'b01);
    check("tmo_cycles_after_rd", lat - arc, TMO);
    check("tmo_resp", rs, 2'b10);
    check("tmo_rdata", rd, 32'hDEAD_DEAD);
    ar_never = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_axil_reg_arbiter
`default_nettype wire
